xor_stream_cipher: RTL and testbench

Parametrised streaming XOR cipher core: successor to the fixed 32-bit-key / 512-bit-message pipeline.
- Loads a KEY_SIZE-bit key serially, LANES bits per beat.
- Encrypts a MSG_SIZE-bit message on the fly: each beat is XORed with the matching key slice, wrapping modulo KEY_SIZE. There is no full-width key expansion or message buffer.
- Adds a rolling-key mode, a bypass mode, a one-cycle-latency output stream with start/end framing, and error flagging.
- Sits between the tt_um top-level pins and the output pads.

---
 rtl/xor_cipher_pkg.sv | 14 +
 rtl/xor_stream_cipher_if.sv | 29 ++
 rtl/xor_key_ring.sv | 57 +++++
 rtl/xor_stream_cipher.sv | 160 ++++++++++++++++
 tb/tb_xor_stream_cipher.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared types and constants for the streaming XOR cipher.
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        S_KEY,
        S_READY,
        S_STREAM
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_ROLL   = 2'b01;
    localparam logic [1:0] MODE_BYPASS = 2'b10;

endpackage

// File: rtl/xor_stream_cipher_if.sv
// Beat-level bus between the pad ring and the cipher core.
interface xor_stream_cipher_if #(
    parameter int LANES = 1
);
    logic             iEn;
    logic [LANES-1:0] iData_in;
    logic             iLoad_key;
    logic             iLoad_msg;
    logic [1:0]       iMode;
    logic [LANES-1:0] oData_out;
    logic             oValid;
    logic             oSerial_start;
    logic             oSerial_end;
    logic             oKey_ready;
    logic             oBusy;
    logic             oError;

    modport master (
        output iEn, iData_in, iLoad_key, iLoad_msg, iMode,
        input  oData_out, oValid, oSerial_start, oSerial_end,
        input  oKey_ready, oBusy, oError
    );

    modport slave (
        input  iEn, iData_in, iLoad_key, iLoad_msg, iMode,
        output oData_out, oValid, oSerial_start, oSerial_end,
        output oKey_ready, oBusy, oError
    );
endinterface

// File: rtl/xor_key_ring.sv
// Key storage plus a per-message working copy that can rotate
// each time the slice index wraps.
module xor_key_ring #(
    parameter int KEY_SIZE = 32,
    parameter int LANES    = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_load,
    input  logic [$clog2(KEY_SIZE)-1:0] i_load_idx,
    input  logic [LANES-1:0]            i_load_data,
    input  logic                        i_start,
    input  logic                        i_adv,
    input  logic                        i_clear,
    input  logic                        i_roll,
    output logic [LANES-1:0]            o_slice
);
    localparam int KW = $clog2(KEY_SIZE);
    localparam int CW = KW + 1;
    localparam logic [CW-1:0] STEP = CW'(LANES);
    localparam logic [CW-1:0] WEND = CW'(KEY_SIZE);

    logic [KEY_SIZE-1:0] r_key;
    logic [KEY_SIZE-1:0] r_work;
    logic [KEY_SIZE-1:0] w_src;
    logic [CW-1:0]       r_kidx;
    logic [CW-1:0]       w_kidx_nxt;
    logic                w_wrap;

    assign w_kidx_nxt = r_kidx + STEP;
    assign w_wrap     = (w_kidx_nxt == WEND);

    // The first beat of a message reads the master key directly,
    // since the working copy is only refreshed at that same edge.
    assign w_src   = i_start ? r_key : r_work;
    assign o_slice = w_src[r_kidx[KW-1:0] +: LANES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key  <= '0;
            r_work <= '0;
            r_kidx <= '0;
        end else begin
            if (i_load) begin
                r_key[i_load_idx +: LANES] <= i_load_data;
            end
            if (i_start) begin
                r_work <= r_key;
            end else if (i_adv && w_wrap && i_roll && !i_clear) begin
                r_work <= {r_work[KEY_SIZE-2:0], r_work[KEY_SIZE-1]};
            end
            if (i_adv) begin
                r_kidx <= (i_clear || w_wrap) ? '0 : w_kidx_nxt;
            end
        end
    end
endmodule

// File: rtl/xor_stream_cipher.sv
// Serial key loader and one-cycle-latency XOR stream encryptor
// with start/end framing and protocol-error flagging.
module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int KEY_SIZE = 32,
    parameter int MSG_SIZE = 512,
    parameter int LANES    = 1
) (
    input logic                iClk,
    input logic                iRst,
    xor_stream_cipher_if.slave bus
);
    localparam int KW  = $clog2(KEY_SIZE);
    localparam int KCW = KW + 1;
    localparam int MCW = $clog2(MSG_SIZE) + 1;
    localparam logic [KCW-1:0] K_STEP = KCW'(LANES);
    localparam logic [KCW-1:0] K_END  = KCW'(KEY_SIZE);
    localparam logic [MCW-1:0] M_STEP = MCW'(LANES);
    localparam logic [MCW-1:0] M_LAST = MCW'(MSG_SIZE - LANES);

    state_t           r_state;
    logic [KCW-1:0]   r_key_cnt;
    logic [MCW-1:0]   r_msg_cnt;
    logic [1:0]       r_mode;
    logic [LANES-1:0] r_data;
    logic             r_valid;
    logic             r_start;
    logic             r_end;
    logic             r_key_ready;
    logic             r_busy;
    logic             r_err;

    logic             w_kbeat;
    logic             w_mbeat;
    logic             w_both;
    logic             w_first;
    logic             w_proc;
    logic             w_last;
    logic             w_load;
    logic [KW-1:0]    w_load_idx;
    logic [1:0]       w_mode;
    logic             w_roll;
    logic             w_byp;
    logic [LANES-1:0] w_slice;
    logic [KCW-1:0]   w_key_cnt_nxt;

    assign w_kbeat = bus.iEn & bus.iLoad_key & ~bus.iLoad_msg;
    assign w_mbeat = bus.iEn & bus.iLoad_msg & ~bus.iLoad_key;
    assign w_both  = bus.iEn & bus.iLoad_key & bus.iLoad_msg;
    assign w_first = w_mbeat & (r_state == S_READY);
    assign w_proc  = w_mbeat & (r_state != S_KEY);
    assign w_last  = (r_msg_cnt == M_LAST);
    assign w_load  = w_kbeat & (r_state != S_STREAM);

    // A key beat in S_READY restarts the key at slice 0.
    assign w_load_idx = (r_state == S_KEY) ? r_key_cnt[KW-1:0] : '0;
    assign w_mode     = w_first ? bus.iMode : r_mode;
    assign w_roll     = (w_mode == MODE_ROLL);
    assign w_byp      = (w_mode == MODE_BYPASS);

    assign w_key_cnt_nxt = r_key_cnt + K_STEP;

    xor_key_ring #(
        .KEY_SIZE(KEY_SIZE),
        .LANES   (LANES)
    ) u_ring (
        .i_clk      (iClk),
        .i_rst      (iRst),
        .i_load     (w_load),
        .i_load_idx (w_load_idx),
        .i_load_data(bus.iData_in),
        .i_start    (w_first),
        .i_adv      (w_proc),
        .i_clear    (w_proc & w_last),
        .i_roll     (w_roll),
        .o_slice    (w_slice)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state     <= S_KEY;
            r_key_cnt   <= '0;
            r_msg_cnt   <= '0;
            r_mode      <= MODE_STATIC;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_key_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else if (!bus.iEn) begin
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_end   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_end   <= 1'b0;
            r_err   <= w_both;
            case (r_state)
                S_KEY: begin
                    if (w_kbeat) begin
                        if (w_key_cnt_nxt == K_END) begin
                            r_key_cnt   <= '0;
                            r_state     <= S_READY;
                            r_key_ready <= 1'b1;
                        end else begin
                            r_key_cnt <= w_key_cnt_nxt;
                        end
                    end
                    if (w_mbeat) begin
                        r_err <= 1'b1;
                    end
                end
                S_READY: begin
                    if (w_kbeat) begin
                        r_key_ready <= 1'b0;
                        r_key_cnt   <= K_STEP;
                        r_state     <= S_KEY;
                    end
                    if (w_mbeat) begin
                        r_mode <= bus.iMode;
                    end
                end
                S_STREAM: begin
                    if (w_kbeat) begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= S_KEY;
            endcase
            if (w_proc) begin
                r_data  <= bus.iData_in ^ (w_byp ? '0 : w_slice);
                r_valid <= 1'b1;
                r_start <= (r_msg_cnt == '0);
                if (w_last) begin
                    r_end     <= 1'b1;
                    r_msg_cnt <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= S_READY;
                end else begin
                    r_msg_cnt <= r_msg_cnt + M_STEP;
                    r_busy    <= 1'b1;
                    r_state   <= S_STREAM;
                end
            end
        end
    end

    assign bus.oData_out     = r_data;
    assign bus.oValid        = r_valid;
    assign bus.oSerial_start = r_start;
    assign bus.oSerial_end   = r_end;
    assign bus.oKey_ready    = r_key_ready;
    assign bus.oBusy         = r_busy;
    assign bus.oError        = r_err;
endmodule

// File: tb/tb_xor_stream_cipher.sv
// Randomised scoreboard bench: a bit-level cipher model feeds
// expectation queues that a negedge monitor drains.
module tb_xor_stream_cipher;
    import xor_cipher_pkg::*;

    localparam int K = 8;
    localparam int M = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    xor_stream_cipher_if #(.LANES(1)) b1 ();
    xor_stream_cipher_if #(.LANES(4)) b4 ();

    xor_stream_cipher #(.KEY_SIZE(K), .MSG_SIZE(M), .LANES(1)) dut1 (
        .iClk(clk), .iRst(rst), .bus(b1)
    );
    xor_stream_cipher #(.KEY_SIZE(K), .MSG_SIZE(M), .LANES(4)) dut4 (
        .iClk(clk), .iRst(rst), .bus(b4)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    typedef struct {
        int   c;
        logic d;
        logic s;
        logic e;
    } exp_t;

    typedef struct {
        int         c;
        logic [3:0] d;
        logic       s;
        logic       e;
    } exp4_t;

    exp_t  q1[$];
    exp4_t q4[$];
    int    eq[$];

    logic [15:0] got1;
    int          gpos;
    logic [15:0] got4;
    int          gpos4;

    // Reference model: key as a bit vector, message as a bit position.
    bit [7:0]   m_key;
    int         m_kn;
    bit         m_ready;
    bit         m_active;
    int         m_pos;
    logic [1:0] m_mode;

    function automatic logic ks_bit(int p);
        int r;
        r = (m_mode == MODE_ROLL) ? (p / K) % K : 0;
        return m_key[((p % K) - r + K) % K];
    endfunction

    task automatic model_reset();
        m_key = '0; m_kn = 0; m_ready = 0; m_active = 0; m_pos = 0;
    endtask

    task automatic drv(bit en, bit lk, bit lm, logic d, logic [1:0] md);
        exp_t e;
        b1.iEn = en; b1.iLoad_key = lk; b1.iLoad_msg = lm;
        b1.iData_in = d; b1.iMode = md;
        if (en) begin
            if (lk && lm) begin
                eq.push_back(cyc + 1);
            end else if (lk) begin
                if (m_active) eq.push_back(cyc + 1);
                else begin
                    if (m_ready) begin m_ready = 0; m_kn = 0; end
                    m_key[m_kn] = d;
                    m_kn++;
                    if (m_kn == K) begin m_kn = 0; m_ready = 1; end
                end
            end else if (lm) begin
                if (!m_ready) eq.push_back(cyc + 1);
                else begin
                    if (!m_active) begin
                        m_active = 1; m_pos = 0; m_mode = md;
                    end
                    e.c = cyc + 1;
                    e.d = d ^ ((m_mode == MODE_BYPASS) ? 1'b0 : ks_bit(m_pos));
                    e.s = (m_pos == 0);
                    e.e = (m_pos == M - 1);
                    q1.push_back(e);
                    m_pos++;
                    if (m_pos == M) m_active = 0;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drv(1, 0, 0, 1'($urandom), 2'($urandom));
    endtask

    task automatic load_key(logic [7:0] k);
        for (int i = 0; i < K; i++) drv(1, 1, 0, k[i], 2'b00);
    endtask

    // gaps: 0 none, 1 enable low before every beat, 2 random stalls
    task automatic send_msg(string nm, logic [15:0] d, logic [1:0] md,
                            int gaps, int inj, bit chkw, logic [15:0] exp);
        gpos = 0;
        for (int i = 0; i < M; i++) begin
            if (gaps == 1) drv(0, 1'($urandom), 1'($urandom), 1'b0, 2'b00);
            if (gaps == 2) begin
                while ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        drv(0, 1'($urandom), 1'($urandom), 1'b0, 2'b00);
                    else
                        idle();
                end
            end
            if (i == inj) drv(1, 1, 0, 1'b1, 2'b00);
            if (i == inj + 3) drv(1, 1, 1, 1'b0, 2'b00);
            drv(1, 0, 1, d[i], (i == 0) ? md : 2'($urandom));
            if (i == 0 && chkw) chk({nm, "_busy_on"}, 32'(b1.oBusy), 1);
        end
        idle();
        if (chkw) begin
            chk({nm, "_word"}, 32'(got1), 32'(exp));
            chk({nm, "_busy_off"}, 32'(b1.oBusy), 0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (b1.oValid === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL spurious_valid: got oValid=1 at cycle %0d expected none", cyc);
            end else begin
                e = q1.pop_front();
                chk("valid_cycle", 32'(cyc), 32'(e.c));
                chk("data", 32'(b1.oData_out), 32'(e.d));
                chk("start", 32'(b1.oSerial_start), 32'(e.s));
                chk("end", 32'(b1.oSerial_end), 32'(e.e));
                if (gpos < 16) got1[gpos] = b1.oData_out[0];
                gpos++;
            end
        end
        if (b1.oError === 1'b1) begin
            if (eq.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL spurious_error: got oError=1 at cycle %0d expected none", cyc);
            end else begin
                chk("error_cycle", 32'(cyc), 32'(eq.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        exp4_t e;
        if (b4.oValid === 1'b1) begin
            if (q4.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL l4_spurious_valid: got oValid=1 at cycle %0d expected none", cyc);
            end else begin
                e = q4.pop_front();
                chk("l4_cycle", 32'(cyc), 32'(e.c));
                chk("l4_data", 32'(b4.oData_out), 32'(e.d));
                chk("l4_start", 32'(b4.oSerial_start), 32'(e.s));
                chk("l4_end", 32'(b4.oSerial_end), 32'(e.e));
                if (gpos4 < 4) got4[gpos4*4 +: 4] = b4.oData_out;
                gpos4++;
            end
        end
        if (b4.oError === 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL l4_error: got oError=1 at cycle %0d expected 0", cyc);
        end
    end

    task automatic drv4(bit lk, bit lm, logic [3:0] d);
        b4.iEn = 1; b4.iLoad_key = lk; b4.iLoad_msg = lm;
        b4.iData_in = d; b4.iMode = MODE_STATIC;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  rk;
        logic [15:0] rd;
        exp4_t       e4;
        b1.iEn = 0; b1.iLoad_key = 0; b1.iLoad_msg = 0;
        b1.iData_in = '0; b1.iMode = '0;
        b4.iEn = 0; b4.iLoad_key = 0; b4.iLoad_msg = 0;
        b4.iData_in = '0; b4.iMode = '0;
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({b1.oData_out, b1.oValid, b1.oSerial_start,
            b1.oSerial_end, b1.oKey_ready, b1.oBusy, b1.oError}), 0);
        rst = 0;

        // protocol errors before any key, then a key beat with both flags
        drv(1, 0, 1, 1'b1, MODE_STATIC);
        drv(1, 1, 1, 1'b1, MODE_STATIC);
        chk("no_key_ready", 32'(b1.oKey_ready), 0);
        load_key(8'hA5);
        chk("key_ready", 32'(b1.oKey_ready), 1);

        send_msg("static0", 16'h0000, MODE_STATIC, 0, -1, 1, 16'hA5A5);
        send_msg("roll0", 16'h0000, MODE_ROLL, 0, -1, 1, 16'h4BA5);
        send_msg("roll1", 16'h0000, MODE_ROLL, 0, -1, 1, 16'h4BA5);
        send_msg("bypass", 16'h1234, MODE_BYPASS, 0, -1, 1, 16'h1234);
        send_msg("static1", 16'h1234, MODE_STATIC, 0, -1, 1, 16'hB791);
        send_msg("mode11", 16'h1234, 2'b11, 0, -1, 1, 16'hB791);
        send_msg("inject", 16'h0000, MODE_STATIC, 0, 5, 1, 16'hA5A5);
        send_msg("en_alt", 16'h0000, MODE_STATIC, 1, -1, 1, 16'hA5A5);
        send_msg("gaps", 16'h0000, MODE_STATIC, 2, -1, 1, 16'hA5A5);

        // reset in the middle of a message
        gpos = 0;
        for (int i = 0; i < 7; i++) drv(1, 0, 1, 1'b0, MODE_STATIC);
        rst = 1;
        b1.iLoad_msg = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        chk("midrst_outputs", 32'({b1.oData_out, b1.oValid, b1.oSerial_start,
            b1.oSerial_end, b1.oKey_ready, b1.oBusy, b1.oError}), 0);
        drv(1, 0, 1, 1'b0, MODE_STATIC);
        load_key(8'hA5);
        send_msg("after_rst", 16'h0000, MODE_STATIC, 0, -1, 1, 16'hA5A5);

        // random keys, data and modes against the model
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                rk = 8'($urandom);
                load_key(rk);
            end
            rd = 16'($urandom);
            send_msg("rand", rd, 2'($urandom), 2,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1,
                     0, 16'h0);
        end
        repeat (3) idle();
        b1.iEn = 0;

        // four-lane instance: key 0xA5 in two nibbles, all-zero message
        for (int i = 0; i < 2; i++) drv4(1, 0, (i == 0) ? 4'h5 : 4'hA);
        gpos4 = 0;
        for (int i = 0; i < 4; i++) begin
            e4.c = cyc + 1;
            e4.d = (i % 2 == 0) ? 4'h5 : 4'hA;
            e4.s = (i == 0);
            e4.e = (i == 3);
            q4.push_back(e4);
            drv4(0, 1, 4'h0);
        end
        drv4(0, 0, 4'h0);
        chk("l4_word", 32'(got4), 32'h0000A5A5);
        chk("l4_busy_off", 32'(b4.oBusy), 0);
        b4.iEn = 0;
        repeat (2) @(posedge clk);
        #1;

        chk("q1_drained", 32'(q1.size()), 0);
        chk("err_drained", 32'(eq.size()), 0);
        chk("q4_drained", 32'(q4.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
